// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline definitions for the MEM stage: access size codes and
// the load/store unit FSM state encoding.
package mem_stage_lsu_pkg;

  // Access size codes carried on EXMEM_AluOP_2
  localparam logic [1:0] SZ_B  = 2'b00;  // byte, sign-extended on load
  localparam logic [1:0] SZ_H  = 2'b01;  // half, sign-extended on load
  localparam logic [1:0] SZ_W  = 2'b10;  // word
  localparam logic [1:0] SZ_BU = 2'b11;  // byte, zero-extended on load

  // Load/store unit FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access outstanding
    REQ  = 2'd1,  // request presented, waiting for dmem_req_ready
    WAIT = 2'd2   // request accepted, waiting for dmem_rsp_valid
  } lsu_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the MEM stage: store strobes and lane-replicated
// store data, load lane extraction with sign/zero extension, and the
// alignment check for the requested access size.
module mem_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half-word out of the returned load word
  assign byte_sel = ld_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  // Lane steering and alignment check by access size
  always_comb begin
    wstrb      = 4'b0000;
    wdata      = st_data;
    ld_data    = ld_word;
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel}
                                 : {24'b0, byte_sel};
      end
      SZ_H: begin
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        ld_data    = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      default: begin
        wstrb      = 4'b1111;
        wdata      = st_data;
        ld_data    = ld_word;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage pipeline. Issues loads and stores on a
// variable-latency data-memory port, stalls the upstream pipeline while an
// access is outstanding, formats load data and registers the MEM/WB outputs.
// Misaligned accesses are dropped and flagged; accesses that outlive the
// timeout are abandoned and flagged as bus errors.
//
// Handshake: a request transfers on a rising edge where dmem_req_valid and
// dmem_req_ready are both 1; once dmem_req_valid rises it and every request
// field stay stable until that edge (or until the access is abandoned on
// timeout). Exactly one dmem_rsp_valid cycle completes an accepted access,
// for stores as well as loads; dmem_rsp_valid outside that window is ignored.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXMEM_AluRES,
  input  logic [31:0] rs2,
  input  logic        EXMEM_WriteBack,
  input  logic        EXMEM_MemoryRead,
  input  logic        EXMEM_MemoryWrite,
  input  logic [4:0]  EXMEM_rd,
  input  logic [1:0]  EXMEM_AluOP_2,
  input  logic [31:0] EXMEM_U_UJ_Load_val,
  input  logic        EXMEM_U_UJ_Load,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        MEMWB_WriteBack,
  output logic [4:0]  MEMWB_rd,
  output logic [31:0] MEMWB_Result,
  output logic        MEMWB_Misaligned,
  output logic        MEMWB_BusErr,
  output lsu_state_t  dbg_state
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  lsu_state_t  state, state_nxt;
  logic [15:0] to_cnt;

  logic        is_mem, is_load, is_store, access, timeout;
  logic        capture, drop_mis, bus_err;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_misaligned;
  logic [31:0] result_nxt;

  mem_align u_align (
    .size       (EXMEM_AluOP_2),
    .addr_lo    (EXMEM_AluRES[1:0]),
    .st_data    (rs2),
    .ld_word    (dmem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ld_data    (al_ld_data),
    .misaligned (al_misaligned)
  );

  // Decode the EX/MEM instruction; a read+write combination is treated as a load
  assign is_mem   = EXMEM_MemoryRead | EXMEM_MemoryWrite;
  assign is_load  = EXMEM_MemoryRead;
  assign is_store = EXMEM_MemoryWrite & ~EXMEM_MemoryRead;
  assign access   = is_mem & ~al_misaligned;
  assign timeout  = (state != IDLE) && (to_cnt == TIMEOUT_LIMIT);

  // Request fields follow the held EX/MEM register directly
  assign dmem_we    = is_store;
  assign dmem_addr  = {EXMEM_AluRES[31:2], 2'b00};
  assign dmem_wdata = al_wdata;
  assign dmem_wstrb = is_store ? al_wstrb : 4'b0000;
  assign dbg_state  = state;

  assign result_nxt = EXMEM_U_UJ_Load ? EXMEM_U_UJ_Load_val
                    : (is_load ? al_ld_data : EXMEM_AluRES);

  // FSM next state, request valid, stall and MEM/WB update selects
  always_comb begin
    state_nxt      = state;
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    capture        = 1'b0;
    drop_mis       = 1'b0;
    bus_err        = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && al_misaligned) begin
          drop_mis = 1'b1;
        end else if (access) begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
          state_nxt      = dmem_req_ready ? WAIT : REQ;
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
          if (dmem_req_ready) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout counter: zero while idle, counts every cycle spent in REQ or WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                to_cnt <= 16'd0;
    else if (state == IDLE) to_cnt <= 16'd0;
    else                    to_cnt <= to_cnt + 16'd1;
  end

  // MEM/WB register: capture a result, or insert a bubble; status flags pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEMWB_WriteBack  <= 1'b0;
      MEMWB_rd         <= 5'd0;
      MEMWB_Result     <= 32'd0;
      MEMWB_Misaligned <= 1'b0;
      MEMWB_BusErr     <= 1'b0;
    end else begin
      MEMWB_Misaligned <= drop_mis;
      MEMWB_BusErr     <= bus_err;
      if (capture) begin
        MEMWB_WriteBack <= EXMEM_WriteBack;
        MEMWB_rd        <= EXMEM_rd;
        MEMWB_Result    <= result_nxt;
      end else begin
        MEMWB_WriteBack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, hand-written reset
// sequence, and randomized instructions checked against a transaction-level
// reference model. The bench plays both the EX/MEM register and the memory.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXMEM_AluRES, rs2, EXMEM_U_UJ_Load_val, dmem_rdata;
  logic        EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite, EXMEM_U_UJ_Load;
  logic [4:0]  EXMEM_rd;
  logic [1:0]  EXMEM_AluOP_2;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, MEMWB_WriteBack, MEMWB_Misaligned, MEMWB_BusErr;
  logic [4:0]  MEMWB_rd;
  logic [31:0] MEMWB_Result;
  lsu_state_t  dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected MEM/WB record: {wb, rd, result, misaligned, buserr}
  logic [39:0] exp_q[$];

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] uval;
    int          rdly;   // req_valid cycles before ready is given
    int          sdly;   // WAIT cycles before rsp_valid is given
    logic        spur;   // drive rsp_valid while not yet accepted
    logic [31:0] rdata;
    logic        e_wb;
    logic [31:0] e_res;
    logic        e_mis;
    logic        e_berr;
    int          e_cyc;  // cycles the instruction occupies the stage
    int          e_hs;   // request handshakes expected
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
  } vec_t;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXMEM_AluRES        (EXMEM_AluRES),
    .rs2                 (rs2),
    .EXMEM_WriteBack     (EXMEM_WriteBack),
    .EXMEM_MemoryRead    (EXMEM_MemoryRead),
    .EXMEM_MemoryWrite   (EXMEM_MemoryWrite),
    .EXMEM_rd            (EXMEM_rd),
    .EXMEM_AluOP_2       (EXMEM_AluOP_2),
    .EXMEM_U_UJ_Load_val (EXMEM_U_UJ_Load_val),
    .EXMEM_U_UJ_Load     (EXMEM_U_UJ_Load),
    .dmem_req_valid      (dmem_req_valid),
    .dmem_req_ready      (dmem_req_ready),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_rsp_valid      (dmem_rsp_valid),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .MEMWB_WriteBack     (MEMWB_WriteBack),
    .MEMWB_rd            (MEMWB_rd),
    .MEMWB_Result        (MEMWB_Result),
    .MEMWB_Misaligned    (MEMWB_Misaligned),
    .MEMWB_BusErr        (MEMWB_BusErr),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Outcome of one instruction from the access rules: alignment by size,
  // completion iff the response arrives within T cycles of REQ+WAIT time.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int a = int'(v.alu % 4);
    logic [31:0] x;
    bit aligned;
    aligned = (v.sz == SZ_H) ? (a % 2 == 0) : (v.sz == SZ_W) ? (a == 0) : 1'b1;
    v.e_wb = 0; v.e_res = 0; v.e_mis = 0; v.e_berr = 0;
    v.e_hs = 0; v.e_strb = 0; v.e_wdata = 0; v.e_cyc = 1;
    if (!(v.mr || v.mw)) begin
      v.e_wb  = v.wb;
      v.e_res = v.u ? v.uval : v.alu;
    end else if (!aligned) begin
      v.e_mis = 1;
    end else begin
      v.e_hs = (v.rdly <= T) ? 1 : 0;
      if (v.mw && !v.mr) begin
        case (v.sz)
          SZ_H:    begin v.e_strb = (a >= 2) ? 4'hC : 4'h3; v.e_wdata = (v.rs2 & 32'hFFFF) * 32'h0001_0001; end
          SZ_W:    begin v.e_strb = 4'hF; v.e_wdata = v.rs2; end
          default: begin v.e_strb = 4'(1 << a); v.e_wdata = (v.rs2 & 32'hFF) * 32'h0101_0101; end
        endcase
      end
      if (v.rdly + v.sdly <= T) begin
        v.e_cyc = v.rdly + v.sdly + 2;
        v.e_wb  = v.wb;
        if (v.u) v.e_res = v.uval;
        else if (!v.mr) v.e_res = v.alu;
        else begin
          case (v.sz)
            SZ_W: x = v.rdata;
            SZ_H: begin
              x = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
              if (x >= 32'h8000) x = x | 32'hFFFF_0000;
            end
            default: begin
              x = (v.rdata >> (8 * a)) & 32'hFF;
              if (v.sz == SZ_B && x >= 32'h80) x = x | 32'hFFFF_FF00;
            end
          endcase
          v.e_res = x;
        end
      end else begin
        v.e_cyc  = T + 2;
        v.e_berr = 1;
      end
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Present one instruction at posedge+1 and hold it while mem_stall is
  // high, answering as the memory per rdly/sdly. Returns at posedge+1.
  task automatic run_instr(input vec_t v, input string tag);
    int cyc = 0, req_cnt = 0, wait_cnt = 0, hs = 0;
    bit accepted = 0, done = 0, rv_s;
    logic [39:0] e;
    EXMEM_AluRES = v.alu; rs2 = v.rs2; EXMEM_WriteBack = v.wb;
    EXMEM_MemoryRead = v.mr; EXMEM_MemoryWrite = v.mw; EXMEM_rd = v.rd;
    EXMEM_AluOP_2 = v.sz; EXMEM_U_UJ_Load = v.u; EXMEM_U_UJ_Load_val = v.uval;
    dmem_rdata = v.rdata;
    exp_q.push_back({v.e_wb, v.rd, v.e_res, v.e_mis, v.e_berr});
    while (!done && cyc < 20) begin
      dmem_req_ready = !accepted && (req_cnt == v.rdly);
      dmem_rsp_valid = accepted ? (wait_cnt == v.sdly) : v.spur;
      @(negedge clk);
      rv_s = dmem_req_valid;
      done = !mem_stall;
      if (rv_s) begin
        chk({tag, "_addr"}, dmem_addr, {v.alu[31:2], 2'b00});
        chk({tag, "_we"}, 32'(dmem_we), 32'(v.mw && !v.mr));
        chk({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(v.e_strb));
        if (v.mw && !v.mr) chk({tag, "_wdata"}, dmem_wdata, v.e_wdata);
      end
      @(posedge clk);
      if (accepted) wait_cnt++;
      else if (rv_s) begin
        if (dmem_req_ready) begin accepted = 1; hs++; end
        else req_cnt++;
      end
      #1;
      cyc++;
      if (!done)
        chk({tag, "_bubble"}, {29'b0, MEMWB_WriteBack, MEMWB_Misaligned, MEMWB_BusErr}, 32'b0);
    end
    e = exp_q.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_done: stall never released within %0d cycles", tag, cyc);
    end else begin
      chk({tag, "_wb"}, 32'(MEMWB_WriteBack), 32'(e[39]));
      chk({tag, "_mis"}, 32'(MEMWB_Misaligned), 32'(e[1]));
      chk({tag, "_berr"}, 32'(MEMWB_BusErr), 32'(e[0]));
      if (e[39]) begin
        chk({tag, "_rd"}, 32'(MEMWB_rd), 32'(e[38:34]));
        chk({tag, "_res"}, MEMWB_Result, e[33:2]);
      end
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(v.e_cyc));
    chk({tag, "_reqs"}, 32'(hs), 32'(v.e_hs));
  endtask

  task automatic drive_nop();
    EXMEM_AluRES = 0; rs2 = 0; EXMEM_WriteBack = 0; EXMEM_MemoryRead = 0;
    EXMEM_MemoryWrite = 0; EXMEM_rd = 0; EXMEM_AluOP_2 = SZ_W;
    EXMEM_U_UJ_Load = 0; EXMEM_U_UJ_Load_val = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tab[18];
    vec_t v;
    int kind;

    // fields: alu, rs2, wb, mr, mw, rd, sz, u, uval, rdly, sdly, spur, rdata,
    //         e_wb, e_res, e_mis, e_berr, e_cyc, e_hs, e_strb, e_wdata
    tab[0]  = '{32'h1234, 0, 1, 0, 0, 5,  SZ_W,  0, 0, 0, 0, 0, 0,             1, 32'h1234,     0, 0, 1, 0, 4'h0, 0};
    tab[1]  = '{32'h100,  0, 1, 1, 0, 7,  SZ_W,  0, 0, 0, 3, 0, 32'hDEADBEEF,  1, 32'hDEADBEEF, 0, 0, 5, 1, 4'h0, 0};
    tab[2]  = '{32'h103,  0, 1, 1, 0, 8,  SZ_B,  0, 0, 1, 0, 0, 32'h80FFFFFF,  1, 32'hFFFFFF80, 0, 0, 3, 1, 4'h0, 0};
    tab[3]  = '{32'h103,  0, 1, 1, 0, 9,  SZ_BU, 0, 0, 0, 0, 0, 32'h80FFFFFF,  1, 32'h00000080, 0, 0, 2, 1, 4'h0, 0};
    tab[4]  = '{32'h202, 32'hAAAA1234, 0, 0, 1, 4, SZ_H, 0, 0, 2, 1, 0, 0,     0, 0,            0, 0, 5, 1, 4'hC, 32'h12341234};
    tab[5]  = '{32'h101,  0, 1, 1, 0, 6,  SZ_W,  0, 0, 0, 0, 0, 0,             0, 0,            1, 0, 1, 0, 4'h0, 0};
    tab[6]  = '{32'h104,  0, 1, 1, 0, 10, SZ_W,  0, 0, 0, 9, 0, 0,             0, 0,            0, 1, 6, 1, 4'h0, 0};
    tab[7]  = '{32'h55,   0, 1, 0, 0, 11, SZ_W,  0, 0, 0, 0, 1, 0,             1, 32'h55,       0, 0, 1, 0, 4'h0, 0};
    tab[8]  = '{32'h999,  0, 1, 0, 0, 3,  SZ_W,  1, 32'hABCDE000, 0, 0, 0, 0,  1, 32'hABCDE000, 0, 0, 1, 0, 4'h0, 0};
    tab[9]  = '{32'h102,  0, 1, 1, 0, 12, SZ_H,  0, 0, 0, 1, 0, 32'h80017FFF,  1, 32'hFFFF8001, 0, 0, 3, 1, 4'h0, 0};
    tab[10] = '{32'h301, 32'h12345655, 0, 0, 1, 0, SZ_B, 0, 0, 1, 2, 0, 0,     0, 0,            0, 0, 5, 1, 4'h2, 32'h55555555};
    tab[11] = '{32'h103,  0, 1, 1, 0, 13, SZ_H,  0, 0, 0, 0, 0, 0,             0, 0,            1, 0, 1, 0, 4'h0, 0};
    tab[12] = '{32'h10, 32'hFFFFFFFF, 1, 1, 1, 14, SZ_W, 0, 0, 0, 0, 0, 32'h11223344, 1, 32'h11223344, 0, 0, 2, 1, 4'h0, 0};
    tab[13] = '{32'h20,   0, 1, 1, 0, 15, SZ_W,  0, 0, 9, 0, 0, 0,             0, 0,            0, 1, 6, 0, 4'h0, 0};
    tab[14] = '{32'h24,   0, 1, 1, 0, 17, SZ_W,  0, 0, 2, 1, 1, 32'h0BADF00D,  1, 32'h0BADF00D, 0, 0, 5, 1, 4'h0, 0};
    tab[15] = '{32'h40, 32'hCAFEF00D, 0, 0, 1, 0, SZ_W, 0, 0, 0, 4, 0, 0,      0, 0,            0, 0, 6, 1, 4'hF, 32'hCAFEF00D};
    tab[16] = '{32'h44,   0, 1, 1, 0, 16, SZ_W,  1, 32'h13579BDF, 0, 0, 0, 32'h2468ACE0, 1, 32'h13579BDF, 0, 0, 2, 1, 4'h0, 0};
    tab[17] = '{32'h48,   0, 1, 1, 0, 18, SZ_W,  0, 0, 2, 3, 0, 32'h12345678,  0, 0,            0, 1, 6, 1, 4'h0, 0};

    // reset block
    rst = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_wb", 32'(MEMWB_WriteBack), 32'd0);
    chk("rst_rd", 32'(MEMWB_rd), 32'd0);
    chk("rst_res", MEMWB_Result, 32'd0);
    chk("rst_flags", {30'b0, MEMWB_Misaligned, MEMWB_BusErr}, 32'd0);
    chk("rst_stall", {30'b0, mem_stall, dmem_req_valid}, 32'd0);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 18; i++) run_instr(tab[i], $sformatf("vec%0d", i));

    // reset while an access is waiting for its response
    v = '{32'h777, 0, 1, 0, 0, 9, SZ_W, 0, 0, 0, 0, 0, 0, 1, 32'h777, 0, 0, 1, 0, 4'h0, 0};
    run_instr(v, "pre_rst");
    EXMEM_AluRES = 32'h20; EXMEM_MemoryRead = 1; EXMEM_MemoryWrite = 0;
    EXMEM_WriteBack = 1; EXMEM_rd = 2; EXMEM_AluOP_2 = SZ_W; EXMEM_U_UJ_Load = 0;
    dmem_req_ready = 1; dmem_rsp_valid = 0;
    @(negedge clk);
    chk("wrst_stall0", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #1;
    dmem_req_ready = 0;
    @(negedge clk);
    chk("wrst_inwait", 32'(dbg_state), 32'(WAIT));
    chk("wrst_stall1", 32'(mem_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("wrst_state", 32'(dbg_state), 32'(IDLE));
    chk("wrst_rd", 32'(MEMWB_rd), 32'd0);
    chk("wrst_res", MEMWB_Result, 32'd0);
    chk("wrst_flags", {29'b0, MEMWB_WriteBack, MEMWB_Misaligned, MEMWB_BusErr}, 32'd0);
    drive_nop();
    @(posedge clk);
    #1 rst = 1'b0;
    v = '{32'h31, 0, 1, 0, 0, 19, SZ_W, 0, 0, 0, 0, 0, 0, 1, 32'h31, 0, 0, 1, 0, 4'h0, 0};
    run_instr(v, "post_rst");

    // randomized instructions against the reference model
    for (int n = 0; n < 80; n++) begin
      kind   = $urandom_range(0, 3);
      v.alu  = $urandom;
      if ($urandom_range(0, 1) == 0) v.alu[1:0] = 2'b00;
      v.rs2  = $urandom;
      v.wb   = 1'($urandom_range(0, 1));
      v.mr   = (kind == 1 || kind == 3);
      v.mw   = (kind == 2 || kind == 3);
      v.rd   = 5'($urandom_range(0, 31));
      v.sz   = 2'($urandom_range(0, 3));
      v.u    = ($urandom_range(0, 7) == 0);
      v.uval = $urandom;
      v.rdly = $urandom_range(0, 3);
      v.sdly = $urandom_range(0, 3);
      v.spur = 1'($urandom_range(0, 1));
      v.rdata = $urandom;
      v = model(v);
      run_instr(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
